// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: runs pump-down then outer-door cycle on arrive,
// pump-up then inner-door cycle on depart, and tracks the chamber pressure level.
module airlock_sequencer #(
    parameter int unsigned PUMP_CYCLES = 7,
    parameter int unsigned DOOR_CYCLES = 3,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arrive_sig,
    input  logic             depart_sig,
    output logic             ev_state,
    output logic             outer_door,
    output logic             inner_door,
    output logic             pump_dn,
    output logic             pump_up,
    output logic [CNT_W-1:0] pressure,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] PumpMax  = CNT_W'(PUMP_CYCLES);
    localparam logic [CNT_W-1:0] PumpLoad = CNT_W'(PUMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DoorLoad = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] One      = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StEvac,
        StOuterOpen,
        StPress,
        StInnerOpen
    } state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] r_pressure;
    logic             r_ev_state;
    logic             r_outer_door;
    logic             r_inner_door;
    logic             r_pump_dn;
    logic             r_pump_up;
    logic             r_busy;
    logic             r_done;

    logic             w_start_arrive;
    logic             w_start_depart;
    logic [CNT_W-1:0] w_pres_dec;
    logic [CNT_W-1:0] w_pres_inc;

    // A request is legal only alone and only from the matching side of the chamber.
    assign w_start_arrive = arrive_sig & ~depart_sig & ~r_ev_state;
    assign w_start_depart = depart_sig & ~arrive_sig &  r_ev_state;

    // Saturating pressure steps; the count never wraps past either end.
    assign w_pres_dec = (r_pressure != '0)      ? r_pressure - One : r_pressure;
    assign w_pres_inc = (r_pressure != PumpMax) ? r_pressure + One : r_pressure;

    // Sequencer FSM with registered outputs; the pump step on entry makes the
    // level change visible in the same cycle the pump output rises.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_timer      <= '0;
            r_pressure   <= PumpMax;
            r_ev_state   <= 1'b0;
            r_outer_door <= 1'b0;
            r_inner_door <= 1'b0;
            r_pump_dn    <= 1'b0;
            r_pump_up    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_start_arrive) begin
                        r_state    <= StEvac;
                        r_timer    <= PumpLoad;
                        r_pressure <= w_pres_dec;
                        r_pump_dn  <= 1'b1;
                        r_busy     <= 1'b1;
                    end else if (w_start_depart) begin
                        r_state    <= StPress;
                        r_timer    <= PumpLoad;
                        r_pressure <= w_pres_inc;
                        r_pump_up  <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                StEvac: begin
                    if (r_timer == '0) begin
                        r_state      <= StOuterOpen;
                        r_timer      <= DoorLoad;
                        r_ev_state   <= 1'b1;
                        r_pump_dn    <= 1'b0;
                        r_outer_door <= 1'b1;
                    end else begin
                        r_timer    <= r_timer - One;
                        r_pressure <= w_pres_dec;
                    end
                end
                StPress: begin
                    if (r_timer == '0) begin
                        r_state      <= StInnerOpen;
                        r_timer      <= DoorLoad;
                        r_ev_state   <= 1'b0;
                        r_pump_up    <= 1'b0;
                        r_inner_door <= 1'b1;
                    end else begin
                        r_timer    <= r_timer - One;
                        r_pressure <= w_pres_inc;
                    end
                end
                StOuterOpen, StInnerOpen: begin
                    if (r_timer == '0) begin
                        r_state      <= StIdle;
                        r_outer_door <= 1'b0;
                        r_inner_door <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                    end else begin
                        r_timer <= r_timer - One;
                    end
                end
                default: begin
                    r_state      <= StIdle;
                    r_timer      <= '0;
                    r_outer_door <= 1'b0;
                    r_inner_door <= 1'b0;
                    r_pump_dn    <= 1'b0;
                    r_pump_up    <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign ev_state   = r_ev_state;
    assign outer_door = r_outer_door;
    assign inner_door = r_inner_door;
    assign pump_dn    = r_pump_dn;
    assign pump_up    = r_pump_up;
    assign pressure   = r_pressure;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
